// File: rtl/vsdma_wr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vsdma_wr_arbiter
// Purpose  : Round-robin sharing of one vsdma write port among NUM_CH channels,
//            with command forwarding, data steering and an acknowledge watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module vsdma_wr_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 28,
    parameter int SIZE_WIDTH  = 16,
    parameter int DATA_WIDTH  = 256,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                         ui_clk,
    input  logic                         ui_rst,
    input  logic [NUM_CH-1:0]            s_wareq,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] s_waddr,
    input  logic [NUM_CH*SIZE_WIDTH-1:0] s_wsize,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_CH-1:0]            s_wvalid,
    output logic [NUM_CH-1:0]            s_wready,
    output logic [NUM_CH-1:0]            s_wbusy,
    output logic [ADDR_WIDTH-1:0]        m_waddr,
    output logic [SIZE_WIDTH-1:0]        m_wsize,
    output logic                         m_wareq,
    input  logic                         m_wbusy,
    output logic [DATA_WIDTH-1:0]        m_wdata,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    output logic [2:0]                   grant_id,
    output logic                         err_timeout
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [NUM_CH-1:0]     r_pending;
    logic [NUM_CH-1:0]     w_clr;
    logic [2:0]            r_last_grant;
    logic [2:0]            r_grant_id;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [SIZE_WIDTH-1:0] r_wsize;
    logic                  r_wareq;
    logic                  r_err;
    logic [7:0]            r_cnt;

    logic                  w_found;
    logic [2:0]            w_pick;
    logic [3:0]            w_scan;
    logic [ADDR_WIDTH-1:0] w_pick_addr;
    logic [SIZE_WIDTH-1:0] w_pick_size;
    logic                  w_grant_en;
    logic                  w_cnt_done;
    logic                  w_abort;
    logic                  w_active;

    // Scan starts one past the last served channel so every pending requester
    // is reached before the same channel can win twice.
    always_comb begin
        w_found     = 1'b0;
        w_pick      = 3'd0;
        w_scan      = 4'd0;
        w_pick_addr = '0;
        w_pick_size = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_scan = {1'b0, r_last_grant} + 4'(k);
            if (w_scan >= 4'(NUM_CH)) begin
                w_scan = w_scan - 4'(NUM_CH);
            end
            if (!w_found && r_pending[w_scan[CW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_scan[2:0];
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_pick == 3'(i)) begin
                w_pick_addr = s_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_pick_size = s_wsize[i*SIZE_WIDTH +: SIZE_WIDTH];
            end
        end
    end

    assign w_grant_en = (r_state == S_IDLE) && w_found;
    assign w_cnt_done = (r_cnt == 8'(ACK_TIMEOUT - 1));
    assign w_abort    = (r_state == S_ISSUE) && !m_wbusy && w_cnt_done;

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_clr[i] = (w_grant_en && (w_pick == 3'(i))) ||
                       (w_abort && (r_grant_id == 3'(i)));
        end
    end

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = S_ISSUE;
            S_ISSUE: begin
                if (m_wbusy) begin
                    w_next = S_BUSY;
                end else if (w_cnt_done) begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY:  if (!m_wbusy) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Set is OR-ed after the clear so a pulse in the grant/abort cycle re-queues.
    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            r_pending    <= '0;
            r_last_grant <= 3'(NUM_CH - 1);
            r_grant_id   <= 3'd0;
            r_waddr      <= '0;
            r_wsize      <= '0;
            r_wareq      <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= 8'd0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | s_wareq;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_waddr    <= w_pick_addr;
                        r_wsize    <= w_pick_size;
                        r_wareq    <= 1'b1;
                        r_cnt      <= 8'd0;
                    end
                end
                S_ISSUE: begin
                    if (m_wbusy) begin
                        r_wareq <= 1'b0;
                        r_cnt   <= 8'd0;
                    end else if (w_cnt_done) begin
                        r_wareq      <= 1'b0;
                        r_err        <= 1'b1;
                        r_last_grant <= r_grant_id;
                        r_cnt        <= 8'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_BUSY: begin
                    if (!m_wbusy) begin
                        r_last_grant <= r_grant_id;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_active = (r_state != S_IDLE);

    always_comb begin
        s_wbusy  = '0;
        s_wready = '0;
        m_wvalid = 1'b0;
        m_wdata  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            s_wbusy[i] = r_pending[i] | (w_active && (r_grant_id == 3'(i)));
            if (w_active && (r_grant_id == 3'(i))) begin
                s_wready[i] = m_wready;
                m_wvalid    = s_wvalid[i];
                m_wdata     = s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign m_waddr     = r_waddr;
    assign m_wsize     = r_wsize;
    assign m_wareq     = r_wareq;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err;

endmodule
`default_nettype wire
